// File: rtl/edge_pulse_array.sv
// Multi-channel input conditioner: per channel a synchroniser, a debounce filter,
// an edge-to-pulse converter selected by edge_sel, and a sticky write-1-to-clear pending bit.
module edge_pulse_array #(
    parameter int CHANNELS        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] level,
    input  logic [1:0]          edge_sel,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic [CW-1:0]          cnt_next;
            logic                   stable_reg;
            logic                   stable_next;
            logic                   pulse_reg;
            logic                   pulse_next;
            logic                   pending_reg;
            logic                   pending_next;
            logic                   sync_out;

            assign sync_out = sync_reg[SYNC_STAGES-1];

            // A new level is accepted only after it has differed from stable on
            // DEBOUNCE_CYCLES consecutive edges; any return to stable restarts the count.
            always_comb begin
                cnt_next     = '0;
                stable_next  = stable_reg;
                pulse_next   = 1'b0;
                if (sync_out != stable_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        stable_next = sync_out;
                        pulse_next  = sync_out ? edge_sel[0] : edge_sel[1];
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                // Set has priority over clear when both land on the same edge.
                pending_next = pulse_reg | (pending_reg & ~clr[gi]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg    <= '0;
                    cnt_reg     <= '0;
                    stable_reg  <= 1'b0;
                    pulse_reg   <= 1'b0;
                    pending_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], level[gi]};
                    cnt_reg     <= cnt_next;
                    stable_reg  <= stable_next;
                    pulse_reg   <= pulse_next;
                    pending_reg <= pending_next;
                end
            end

            assign stable[gi]  = stable_reg;
            assign pulse[gi]   = pulse_reg;
            assign pending[gi] = pending_reg;
        end
    endgenerate

    assign irq = |pending;

endmodule

// File: tb/tb_edge_pulse_array.sv
// Bench for edge_pulse_array: directed scenarios on two parameterisations plus a
// randomized run against a sliding-window reference model.
module tb_edge_pulse_array;

    localparam int S_B = 2;
    localparam int D_B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] edge_sel;
    logic [3:0] level_a, clr_a, stable_a, pulse_a, pending_a;
    logic       irq_a;
    logic [1:0] level_b, clr_b, stable_b, pulse_b, pending_b;
    logic       irq_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edge_pulse_array #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .level(level_a), .edge_sel(edge_sel), .clr(clr_a),
        .stable(stable_a), .pulse(pulse_a), .pending(pending_a), .irq(irq_a)
    );

    edge_pulse_array #(.CHANNELS(2), .SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B)) u_b (
        .clk(clk), .rst(rst), .level(level_b), .edge_sel(edge_sel), .clr(clr_b),
        .stable(stable_b), .pulse(pulse_b), .pending(pending_b), .irq(irq_b)
    );

    // Reference model for instance B: a channel accepts a new level when the last
    // D synchronised samples (levels seen S edges earlier) all differ from stable.
    logic [1:0] lvq[$];
    logic [1:0] m_stable, m_pulse, m_pend;

    task automatic model_reset();
        lvq.delete();
        for (int i = 0; i < S_B + D_B; i++) lvq.push_back(2'b00);
        m_stable = '0;
        m_pulse  = '0;
        m_pend   = '0;
    endtask

    task automatic model_edge(input logic [1:0] lv, input logic [1:0] cl, input logic [1:0] sel);
        logic all_diff;
        lvq.push_back(lv);
        for (int ch = 0; ch < 2; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D_B; j++)
                if (lvq[lvq.size() - 1 - S_B - j][ch] == m_stable[ch]) all_diff = 1'b0;
            m_pend[ch] = m_pulse[ch] | (m_pend[ch] & ~cl[ch]);
            if (all_diff) begin
                m_stable[ch] = ~m_stable[ch];
                m_pulse[ch]  = m_stable[ch] ? sel[0] : sel[1];
            end else begin
                m_pulse[ch] = 1'b0;
            end
        end
        while (lvq.size() > S_B + D_B) void'(lvq.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; level_a = '0; clr_a = '0; level_b = '0; clr_b = '0; edge_sel = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({stable_a, pulse_a, pending_a, irq_a} !== 13'd0) begin
            n_err++; $display("FAIL reset_a: got %h expected 0", {stable_a, pulse_a, pending_a, irq_a});
        end
        n_cmp++;
        if ({stable_b, pulse_b, pending_b, irq_b} !== 7'd0) begin
            n_err++; $display("FAIL reset_b: got %h expected 0", {stable_b, pulse_b, pending_b, irq_b});
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        edge_sel = 2'b01; level_a = '0;
        do_reset();
        level_a = 4'b0001;
        tick(); tick();
        n_cmp++;
        if (stable_a !== 4'b0000) begin
            n_err++; $display("FAIL basic_early: stable=%b expected 0000", stable_a);
        end
        tick();
        n_cmp++;
        if (stable_a !== 4'b0001 || pulse_a !== 4'b0001 || pending_a !== 4'b0000) begin
            n_err++; $display("FAIL basic_e3: stable=%b pulse=%b pending=%b expected 0001/0001/0000",
                              stable_a, pulse_a, pending_a);
        end
        tick();
        n_cmp++;
        if (pulse_a !== 4'b0000 || pending_a !== 4'b0001 || irq_a !== 1'b1) begin
            n_err++; $display("FAIL basic_e4: pulse=%b pending=%b irq=%b expected 0000/0001/1",
                              pulse_a, pending_a, irq_a);
        end
        $display("test_basic done");
    endtask

    task automatic test_back_to_back();
        edge_sel = 2'b11; level_a = '0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            level_a[0] = (i % 2 == 0);
            tick();
            if (i + 1 >= 3) begin
                n_cmp++;
                if (pulse_a[0] !== 1'b1 || stable_a[0] !== logic'((i - 2) % 2 == 0)) begin
                    n_err++; $display("FAIL b2b_edge%0d: pulse=%b stable=%b expected 1/%0d",
                                      i + 1, pulse_a[0], stable_a[0], ((i - 2) % 2 == 0));
                end
            end
        end
        level_a = '0;
        $display("test_back_to_back done");
    endtask

    task automatic test_edge_select();
        int       npulse;
        logic     pulse_on_fall;
        logic [2:0] seq3;
        edge_sel = 2'b10; level_a = '0;
        do_reset();
        npulse = 0; pulse_on_fall = 1'b1;
        seq3 = 3'b101;
        for (int s = 0; s < 3; s++) begin
            level_a[1] = seq3[s];
            for (int t = 0; t < 8; t++) begin
                tick();
                if (pulse_a[1]) begin
                    npulse++;
                    if (stable_a[1] !== 1'b0) pulse_on_fall = 1'b0;
                end
            end
            n_cmp++;
            if (stable_a[1] !== seq3[s]) begin
                n_err++; $display("FAIL sel10_stable%0d: got %b expected %b", s, stable_a[1], seq3[s]);
            end
        end
        n_cmp++;
        if (npulse != 1 || !pulse_on_fall) begin
            n_err++; $display("FAIL sel10_pulses: count=%0d on_fall=%b expected 1/1", npulse, pulse_on_fall);
        end
        edge_sel = 2'b00; npulse = 0;
        for (int s = 0; s < 2; s++) begin
            level_a[1] = (s == 1);
            for (int t = 0; t < 8; t++) begin
                tick();
                if (pulse_a[1]) npulse++;
            end
            n_cmp++;
            if (stable_a[1] !== logic'(s == 1)) begin
                n_err++; $display("FAIL sel00_stable%0d: got %b expected %0d", s, stable_a[1], (s == 1));
            end
        end
        n_cmp++;
        if (npulse != 0) begin
            n_err++; $display("FAIL sel00_pulses: count=%0d expected 0", npulse);
        end
        level_a = '0;
        $display("test_edge_select done");
    endtask

    task automatic test_pending();
        edge_sel = 2'b01; level_a = '0; clr_a = '0;
        do_reset();
        level_a = 4'b1000;
        tick();
        level_a = 4'b1100;
        tick(); tick(); tick();
        n_cmp++;
        if (pulse_a !== 4'b0100 || pending_a !== 4'b1000) begin
            n_err++; $display("FAIL pend_setup: pulse=%b pending=%b expected 0100/1000", pulse_a, pending_a);
        end
        clr_a = 4'b0100;
        tick();
        n_cmp++;
        if (pending_a !== 4'b1100) begin
            n_err++; $display("FAIL pend_set_wins: got %b expected 1100", pending_a);
        end
        tick();
        n_cmp++;
        if (pending_a !== 4'b1000 || irq_a !== 1'b1) begin
            n_err++; $display("FAIL pend_clear: pending=%b irq=%b expected 1000/1", pending_a, irq_a);
        end
        clr_a = 4'b0001;
        tick();
        n_cmp++;
        if (pending_a !== 4'b1000) begin
            n_err++; $display("FAIL pend_clr_idle: got %b expected 1000", pending_a);
        end
        clr_a = 4'b1000;
        tick();
        n_cmp++;
        if (pending_a !== 4'b0000 || irq_a !== 1'b0) begin
            n_err++; $display("FAIL pend_all_clear: pending=%b irq=%b expected 0000/0", pending_a, irq_a);
        end
        clr_a = '0; level_a = '0;
        $display("test_pending done");
    endtask

    task automatic test_glitch();
        int npulse;
        int first_t, second_t;
        edge_sel = 2'b11; level_b = '0; clr_b = '0;
        do_reset();
        npulse = 0;
        level_b = 2'b01;
        for (int t = 1; t <= 12; t++) begin
            if (t == 4) level_b = 2'b00;
            tick();
            if (pulse_b[0] || stable_b[0]) npulse++;
        end
        n_cmp++;
        if (npulse != 0) begin
            n_err++; $display("FAIL glitch: %0d cycles with stable/pulse high, expected 0", npulse);
        end
        npulse = 0; first_t = -1; second_t = -1;
        level_b = 2'b01;
        for (int t = 1; t <= 16; t++) begin
            if (t == 5) level_b = 2'b00;
            tick();
            if (pulse_b[0]) begin
                npulse++;
                if (first_t < 0) begin
                    first_t = t;
                    n_cmp++;
                    if (stable_b[0] !== 1'b1) begin
                        n_err++; $display("FAIL glitch_rise_level: stable=%b expected 1", stable_b[0]);
                    end
                end else second_t = t;
            end
        end
        n_cmp++;
        if (npulse != 2 || first_t != 6 || second_t != 10) begin
            n_err++; $display("FAIL hold_pulses: count=%0d at %0d,%0d expected 2 at 6,10",
                              npulse, first_t, second_t);
        end
        n_cmp++;
        if (stable_b[0] !== 1'b0 || pending_b[0] !== 1'b1) begin
            n_err++; $display("FAIL hold_end: stable=%b pending=%b expected 0/1", stable_b[0], pending_b[0]);
        end
        $display("test_glitch done");
    endtask

    task automatic test_reset_mid();
        edge_sel = 2'b11; clr_b = '0;
        level_b = 2'b10;
        for (int t = 0; t < 10; t++) tick();
        n_cmp++;
        if (stable_b !== 2'b10 || pending_b !== 2'b11) begin
            n_err++; $display("FAIL rmid_setup: stable=%b pending=%b expected 10/11", stable_b, pending_b);
        end
        level_b = 2'b11;
        for (int t = 0; t < 4; t++) tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({stable_b, pulse_b, pending_b, irq_b} !== 7'd0) begin
            n_err++; $display("FAIL rmid_async: got %h expected 0", {stable_b, pulse_b, pending_b, irq_b});
        end
        @(negedge clk);
        level_b = 2'b01;
        rst = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        n_cmp++;
        if (stable_b !== 2'b00) begin
            n_err++; $display("FAIL rmid_early: stable=%b expected 00", stable_b);
        end
        tick();
        n_cmp++;
        if (stable_b !== 2'b01 || pulse_b !== 2'b01) begin
            n_err++; $display("FAIL rmid_refilter: stable=%b pulse=%b expected 01/01", stable_b, pulse_b);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [6:0] got, exp;
        int         errs_before;
        errs_before = n_err;
        level_b = '0; clr_b = '0; edge_sel = 2'b11;
        do_reset();
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            exp = {m_stable, m_pulse, m_pend, |m_pend};
            got = {stable_b, pulse_b, pending_b, irq_b};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                if (n_err - errs_before <= 20)
                    $display("FAIL random_cyc%0d: got %b expected %b", c, got, exp);
            end
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(0, 4) == 0) level_b[ch] = ~level_b[ch];
            clr_b = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 149) == 0) edge_sel = 2'($urandom);
            @(posedge clk);
            model_edge(level_b, clr_b, edge_sel);
            @(negedge clk);
        end
        $display("test_random done: %0d errors", n_err - errs_before);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_edge_select();
        test_pending();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
